// File: rtl/usb_word_serializer_pkg.sv
// rtl/usb_word_serializer_pkg.sv - shared constants and byte-select helper for the USB word serializer
package usb_word_serializer_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam bit LSB_FIRST      = 1'b1;
  localparam logic [7:0] USB_IDLE_BYTE = 8'h00;

  typedef logic [1:0] byte_idx_t;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input byte_idx_t bi);
    logic [1:0] sel;
    sel = LSB_FIRST ? bi : 2'(BYTES_PER_WORD - 1 - int'(bi));
    return w[8*sel +: 8];
  endfunction

endpackage

// File: rtl/usb_ser_word_fifo.sv
// rtl/usb_ser_word_fifo.sv - synchronous DEPTH x 32 word buffer, registered pointers, no fall-through
module usb_ser_word_fifo
  import usb_word_serializer_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int ABITS = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  output logic [31:0]      rd_data,
  output logic             full,
  output logic             empty,
  output logic [ABITS:0]   level
);

  logic [31:0]      mem [DEPTH];
  logic [ABITS-1:0] wr_ptr;
  logic [ABITS-1:0] rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // A write into a full buffer is legal only when the same edge pops a word.
  assign do_wr   = wr_en & (~full | rd_en);
  assign do_rd   = rd_en & ~empty;
  assign full    = (level == (ABITS+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/usb_word_serializer.sv
// rtl/usb_word_serializer.sv - word buffer plus head register serialising 32-bit words to USB bytes; optional USB_SER_BYTE_CNT_EN
module usb_word_serializer
  import usb_word_serializer_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int NEAR_FULL_GAP = 4,
  localparam int ABITS        = $clog2(DEPTH)
) (
  input  logic             BUS_CLK,
  input  logic             BUS_RST_B,
  input  logic [31:0]      FIFO_DATA,
  input  logic             FIFO_EMPTY_IN,
  output logic             FIFO_READ_NEXT_OUT,
  input  logic             USB_READ,
  output logic [7:0]       USB_DATA,
  output logic             FIFO_NOT_EMPTY,
  output logic             FIFO_FULL,
  output logic             FIFO_NEAR_FULL,
  output logic             FIFO_READ_ERROR,
  input  logic             CLEAR_ERR,
  output logic [ABITS:0]   WORD_COUNT
`ifdef USB_SER_BYTE_CNT_EN
  ,
  output logic [31:0]      BYTE_CNT
`endif
);

  logic [31:0]   head;
  byte_idx_t     bi;
  logic          head_valid;
  logic          active;
  logic          err;
  logic [31:0]   buf_rd_data;
  logic          buf_full;
  logic          buf_empty;
  logic [ABITS:0] buf_level;
  logic          good_read;
  logic          pop;

  usb_ser_word_fifo #(.DEPTH(DEPTH)) u_buf (
    .clk     (BUS_CLK),
    .rst_n   (BUS_RST_B),
    .wr_en   (FIFO_READ_NEXT_OUT),
    .wr_data (FIFO_DATA),
    .rd_en   (pop),
    .rd_data (buf_rd_data),
    .full    (buf_full),
    .empty   (buf_empty),
    .level   (buf_level)
  );

  assign good_read = USB_READ & head_valid;
  // Refill an idle head, or swap in the next word on the last byte so strobes never bubble.
  assign pop = ~buf_empty & (~head_valid | (good_read & (bi == 2'd3)));

  // Holds off the arbiter handshake until the first edge after reset release.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
    if (!BUS_RST_B) active <= 1'b0;
    else            active <= 1'b1;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
    if (!BUS_RST_B) begin
      head       <= '0;
      bi         <= '0;
      head_valid <= 1'b0;
    end else if (pop) begin
      head       <= buf_rd_data;
      bi         <= '0;
      head_valid <= 1'b1;
    end else if (good_read) begin
      bi <= bi + 1'b1;
      if (bi == 2'd3) head_valid <= 1'b0;
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
    if (!BUS_RST_B)                  err <= 1'b0;
    else if (USB_READ & ~head_valid) err <= 1'b1;
    else if (CLEAR_ERR)              err <= 1'b0;
  end

`ifdef USB_SER_BYTE_CNT_EN
  always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
    if (!BUS_RST_B)     BYTE_CNT <= '0;
    else if (CLEAR_ERR) BYTE_CNT <= '0;
    else if (good_read) BYTE_CNT <= BYTE_CNT + 32'd1;
  end
`endif

  assign WORD_COUNT         = buf_level + (ABITS+1)'(head_valid);
  assign FIFO_FULL          = buf_full & head_valid;
  assign FIFO_NEAR_FULL     = int'(WORD_COUNT) >= (DEPTH + 1 - NEAR_FULL_GAP);
  assign FIFO_READ_NEXT_OUT = active & ~FIFO_EMPTY_IN & ~FIFO_FULL;
  assign FIFO_NOT_EMPTY     = head_valid;
  assign FIFO_READ_ERROR    = err;
  assign USB_DATA           = head_valid ? word_byte(head, bi) : USB_IDLE_BYTE;

endmodule

// File: tb/tb_usb_word_serializer.sv
// tb/tb_usb_word_serializer.sv - scoreboard bench for usb_word_serializer; BYTE_CNT checks under USB_SER_BYTE_CNT_EN
module tb_usb_word_serializer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fifo_data = '0;
  logic        fifo_empty_in = 1'b1;
  logic        fifo_read_next_out;
  logic        usb_read = 1'b0;
  logic [7:0]  usb_data;
  logic        fifo_not_empty;
  logic        fifo_full;
  logic        fifo_near_full;
  logic        fifo_read_error;
  logic        clear_err = 1'b0;
  logic [4:0]  word_count;
`ifdef USB_SER_BYTE_CNT_EN
  logic [31:0] byte_cnt;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  usb_word_serializer dut (
    .BUS_CLK            (clk),
    .BUS_RST_B          (rst_n),
    .FIFO_DATA          (fifo_data),
    .FIFO_EMPTY_IN      (fifo_empty_in),
    .FIFO_READ_NEXT_OUT (fifo_read_next_out),
    .USB_READ           (usb_read),
    .USB_DATA           (usb_data),
    .FIFO_NOT_EMPTY     (fifo_not_empty),
    .FIFO_FULL          (fifo_full),
    .FIFO_NEAR_FULL     (fifo_near_full),
    .FIFO_READ_ERROR    (fifo_read_error),
    .CLEAR_ERR          (clear_err),
    .WORD_COUNT         (word_count)
`ifdef USB_SER_BYTE_CNT_EN
    ,
    .BYTE_CNT           (byte_cnt)
`endif
  );

  // Drive one word for one cycle; record its bytes LSB first if the handshake takes it.
  task automatic push_word(input logic [31:0] w, output logic acc);
    fifo_data = w;
    fifo_empty_in = 1'b0;
    @(negedge clk);
    acc = fifo_read_next_out;
    if (acc) for (int k = 0; k < 4; k++) sb.push_back(8'((w >> (8*k)) & 32'hFF));
    @(posedge clk); #1;
    fifo_empty_in = 1'b1;
  endtask

  task automatic strobe(output logic [7:0] d, output logic ne);
    usb_read = 1'b1;
    @(negedge clk);
    d = usb_data;
    ne = fifo_not_empty;
    @(posedge clk); #1;
    usb_read = 1'b0;
  endtask

  task automatic wait_head(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fifo_not_empty) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (usb_data !== 8'h00) begin bad++; $display("FAIL reset_usb_data got=%h exp=00", usb_data); end
    total++; if ({fifo_not_empty, fifo_full, fifo_near_full, fifo_read_error} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {fifo_not_empty, fifo_full, fifo_near_full, fifo_read_error}); end
    total++; if (word_count !== 5'd0) begin bad++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic acc, ok, ne;
    logic [7:0] d, e;
    push_word(32'h44332211, acc);
    total++; if (acc !== 1'b1) begin bad++; $display("FAIL single_accept got=%b exp=1", acc); end
    wait_head(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL single_head_timeout got=%b exp=1", ok); end
    for (int k = 0; k < 4; k++) begin
      strobe(d, ne);
      e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      total++; if (d !== e || ne !== 1'b1) begin bad++; $display("FAIL single_byte%0d got=%h/%b exp=%h/1", k, d, ne, e); end
    end
    @(negedge clk);
    total++; if (fifo_not_empty !== 1'b0) begin bad++; $display("FAIL single_empty_after got=%b exp=0", fifo_not_empty); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic acc, ok, ne;
    logic [7:0] d, e;
    push_word(32'hAABBCCDD, acc);
    push_word(32'h01020304, acc);
    wait_head(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL b2b_head_timeout got=%b exp=1", ok); end
    for (int k = 0; k < 8; k++) begin
      strobe(d, ne);
      e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      total++; if (d !== e || ne !== 1'b1) begin bad++; $display("FAIL b2b_byte%0d got=%h/%b exp=%h/1", k, d, ne, e); end
    end
    @(negedge clk);
    total++; if (fifo_not_empty !== 1'b0) begin bad++; $display("FAIL b2b_empty_after got=%b exp=0", fifo_not_empty); end
    @(posedge clk); #1;
  endtask

  task automatic test_full();
    int n = 0;
    int guard = 0;
    logic ne;
    logic [7:0] d, e;
    fifo_empty_in = 1'b0;
    for (int i = 0; i < 22; i++) begin
      fifo_data = 32'hC0DE0000 + 32'(i);
      @(negedge clk);
      total++; if (word_count !== 5'(n)) begin bad++; $display("FAIL full_word_count got=%0d exp=%0d", word_count, n); end
      total++; if (fifo_full !== (n == DEPTH + 1)) begin bad++; $display("FAIL full_flag n=%0d got=%b", n, fifo_full); end
      total++; if (fifo_near_full !== (n >= DEPTH + 1 - 4)) begin bad++; $display("FAIL near_full n=%0d got=%b", n, fifo_near_full); end
      total++; if (fifo_read_next_out !== (n < DEPTH + 1)) begin bad++; $display("FAIL full_read_next n=%0d got=%b", n, fifo_read_next_out); end
      if (fifo_read_next_out) begin
        n++;
        for (int k = 0; k < 4; k++) sb.push_back(8'((fifo_data >> (8*k)) & 32'hFF));
      end
      @(posedge clk); #1;
    end
    fifo_empty_in = 1'b1;
    while (sb.size() > 0 && guard < 100) begin
      guard++;
      strobe(d, ne);
      e = sb.pop_front();
      total++; if (d !== e || ne !== 1'b1) begin bad++; $display("FAIL drain_byte%0d got=%h/%b exp=%h/1", guard, d, ne, e); end
    end
    @(negedge clk);
    total++; if (fifo_not_empty !== 1'b0 || word_count !== 5'd0) begin
      bad++; $display("FAIL drain_end got=%b/%0d exp=0/0", fifo_not_empty, word_count); end
    @(posedge clk); #1;
  endtask

  task automatic test_error();
    logic ne;
    logic [7:0] d;
    strobe(d, ne);
    total++; if (d !== 8'h00 || ne !== 1'b0) begin bad++; $display("FAIL err_bad_read_data got=%h/%b exp=00/0", d, ne); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (fifo_read_error !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", fifo_read_error); end
    @(posedge clk); #1;
    clear_err = 1'b1;
    strobe(d, ne);
    clear_err = 1'b0;
    @(negedge clk);
    total++; if (fifo_read_error !== 1'b1) begin bad++; $display("FAIL err_set_priority got=%b exp=1", fifo_read_error); end
    @(posedge clk); #1;
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    @(negedge clk);
    total++; if (fifo_read_error !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", fifo_read_error); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_word();
    logic acc, ok, ne;
    logic [7:0] d, e;
    push_word(32'h88776655, acc);
    wait_head(ok);
    for (int k = 0; k < 2; k++) begin
      strobe(d, ne);
      e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      total++; if (d !== e) begin bad++; $display("FAIL mid_byte%0d got=%h exp=%h", k, d, e); end
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (usb_data !== 8'h00 || fifo_not_empty !== 1'b0 || word_count !== 5'd0) begin
      bad++; $display("FAIL async_reset got=%h/%b/%0d exp=00/0/0", usb_data, fifo_not_empty, word_count); end
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_word(32'hDEADBEEF, acc);
    wait_head(ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL post_reset_head_timeout got=%b exp=1", ok); end
    for (int k = 0; k < 4; k++) begin
      strobe(d, ne);
      e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
      total++; if (d !== e) begin bad++; $display("FAIL post_reset_byte%0d got=%h exp=%h", k, d, e); end
    end
  endtask

`ifdef USB_SER_BYTE_CNT_EN
  task automatic test_byte_cnt();
    logic acc, ok, ne;
    logic [7:0] d;
    int good = 0;
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    push_word(32'h11111111, acc);
    push_word(32'h22222222, acc);
    wait_head(ok);
    for (int k = 0; k < 8; k++) begin strobe(d, ne); if (ne) good++; end
    strobe(d, ne);
    if (ne) good++;
    push_word(32'h33333333, acc);
    wait_head(ok);
    for (int k = 0; k < 2; k++) begin strobe(d, ne); if (ne) good++; end
    @(negedge clk);
    total++; if (byte_cnt !== 32'd10) begin bad++; $display("FAIL byte_cnt got=%0d exp=10 (seen=%0d)", byte_cnt, good); end
    @(posedge clk); #1;
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    @(negedge clk);
    total++; if (byte_cnt !== 32'd0) begin bad++; $display("FAIL byte_cnt_clear got=%0d exp=0", byte_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_error();
    test_reset_mid_word();
`ifdef USB_SER_BYTE_CNT_EN
    test_byte_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
